// File: rtl/cdb_broadcaster.sv
// Common data bus transmit side: per-FU one-entry result buffers, round-robin arbitration and a
// registered broadcast. Define CDB_BYPASS_EN to let an empty-buffer FU win directly (1-cycle path).
module cdb_broadcaster #(
    parameter int unsigned N_FU  = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        flush,
    input  logic [N_FU-1:0]             fu_valid,
    input  logic [N_FU-1:0][TAG_W-1:0]  fu_tag,
    input  logic [N_FU-1:0][31:0]       fu_data,
    output logic [N_FU-1:0]             fu_ready,
    output logic [TAG_W+31:0]           cdb_out,
    output logic [N_FU-1:0]             cdb_grant
);
    localparam int unsigned IDX_W = $clog2(N_FU);
    localparam logic [TAG_W-1:0] INVALID = '0;

    logic [N_FU-1:0]            full_q;
    logic [N_FU-1:0][TAG_W-1:0] tag_q;
    logic [N_FU-1:0][31:0]      data_q;
    logic [IDX_W-1:0]           rr_ptr;

    logic [N_FU-1:0]  cand;
    logic [N_FU-1:0]  grant;
    logic [N_FU-1:0]  take_bypass;
    logic             found;
    logic [IDX_W-1:0] win;
    logic [TAG_W-1:0] win_tag;
    logic [31:0]      win_data;

    always_comb begin
        cand        = full_q;
        take_bypass = '0;
`ifdef CDB_BYPASS_EN
        for (int i = 0; i < N_FU; i++) begin
            if (!full_q[i] && fu_valid[i] && fu_tag[i] != INVALID) cand[i] = 1'b1;
        end
`endif
        found = 1'b0;
        win   = '0;
        // First candidate at or after rr_ptr, wrapping past the top index.
        for (int off = 0; off < N_FU; off++) begin
            int idx;
            idx = (int'(rr_ptr) + off) % N_FU;
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
        grant = '0;
        if (found) grant[win] = 1'b1;
        win_tag  = tag_q[win];
        win_data = data_q[win];
`ifdef CDB_BYPASS_EN
        take_bypass = grant & ~full_q;
        if (!full_q[win]) begin
            win_tag  = fu_tag[win];
            win_data = fu_data[win];
        end
`endif
        fu_ready = flush ? '0 : (~full_q | grant);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            full_q    <= '0;
            tag_q     <= '0;
            data_q    <= '0;
            rr_ptr    <= '0;
            cdb_out   <= {INVALID, 32'h0};
            cdb_grant <= '0;
        end else if (flush) begin
            full_q    <= '0;
            cdb_out   <= {INVALID, 32'h0};
            cdb_grant <= '0;
        end else begin
            if (found) begin
                cdb_out   <= {win_tag, win_data};
                cdb_grant <= grant;
                rr_ptr    <= (win == IDX_W'(N_FU - 1)) ? '0 : win + 1'b1;
            end else begin
                cdb_out   <= {INVALID, 32'h0};
                cdb_grant <= '0;
            end
            for (int i = 0; i < N_FU; i++) begin
                // A refill on the granted FU overrides the clear so full stays set.
                if (fu_valid[i] && fu_ready[i] && fu_tag[i] != INVALID && !take_bypass[i]) begin
                    full_q[i] <= 1'b1;
                    tag_q[i]  <= fu_tag[i];
                    data_q[i] <= fu_data[i];
                end else if (grant[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Randomized bench for cdb_broadcaster: a cycle model of the bus rules plus per-FU order scoreboards.
module tb_cdb_broadcaster;
    localparam int N  = 4;
    localparam int TW = 4;
`ifdef CDB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic               CLK = 1'b0;
    logic               RST;
    logic               flush;
    logic [N-1:0]       fu_valid;
    logic [N-1:0][TW-1:0] fu_tag;
    logic [N-1:0][31:0] fu_data;
    logic [N-1:0]       fu_ready;
    logic [TW+31:0]     cdb_out;
    logic [N-1:0]       cdb_grant;

    cdb_broadcaster #(.N_FU(N), .TAG_W(TW)) dut (
        .CLK(CLK), .RST(RST), .flush(flush), .fu_valid(fu_valid), .fu_tag(fu_tag),
        .fu_data(fu_data), .fu_ready(fu_ready), .cdb_out(cdb_out), .cdb_grant(cdb_grant)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // FU-side stimulus: pending result per FU, held until accepted.
    bit            pv[N];
    logic [TW-1:0] pt[N];
    logic [31:0]   pd[N];
    bit            auto_mask[N];
    int            prob = 0;
    bit            pflush = 0;

    // Reference model state (as seen after the most recent edge).
    bit            mf[N];
    logic [TW-1:0] mt[N];
    logic [31:0]   md[N];
    int            mrr;
    logic [TW-1:0] mct;
    logic [31:0]   mcd;
    logic [N-1:0]  mg;

    logic [TW+31:0] sb[N][$];

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mf[i] = 0; mt[i] = '0; md[i] = '0; pv[i] = 0; sb[i].delete();
        end
        mrr = 0; mct = '0; mcd = '0; mg = '0; pflush = 0;
    endtask

    task automatic step();
        int win;
        bit cand[N];
        bit rdy[N];
        bit byp[N];
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            fu_valid[i] = pv[i]; fu_tag[i] = pt[i]; fu_data[i] = pd[i];
        end
        flush = pflush;
        @(negedge CLK);
        check("cdb_tag", 64'(cdb_out[TW+31:32]), 64'(mct));
        check("cdb_data", 64'(cdb_out[31:0]), 64'(mcd));
        check("cdb_grant", 64'(cdb_grant), 64'(mg));
        win = -1;
        for (int i = 0; i < N; i++) begin
            cand[i] = mf[i];
`ifdef CDB_BYPASS_EN
            cand[i] = mf[i] || (pv[i] && pt[i] != '0);
`endif
        end
        for (int off = 0; off < N; off++) begin
            int k;
            k = (mrr + off) % N;
            if (win < 0 && cand[k]) win = k;
        end
        for (int i = 0; i < N; i++) begin
            rdy[i] = !pflush && (!mf[i] || win == i);
            r[i]   = rdy[i];
        end
        check("fu_ready", 64'(fu_ready), 64'(r));
        // Each FU's results must reach the bus exactly once and in acceptance order.
        for (int i = 0; i < N; i++) begin
            if (cdb_grant[i]) begin
                if (sb[i].size() == 0) check("sb_spurious", 64'(cdb_out), 64'hFFFF_FFFF_FFFF_FFFF);
                else check("sb_order", 64'(cdb_out), 64'(sb[i].pop_front()));
            end
        end
        for (int i = 0; i < N; i++)
            if (fu_valid[i] && fu_ready[i] && fu_tag[i] != '0) sb[i].push_back({fu_tag[i], fu_data[i]});
        if (pflush) for (int i = 0; i < N; i++) sb[i].delete();
        if (pflush) begin
            for (int i = 0; i < N; i++) mf[i] = 0;
            mct = '0; mcd = '0; mg = '0;
        end else begin
            for (int i = 0; i < N; i++) byp[i] = (win == i) && !mf[i];
            if (win >= 0) begin
                if (mf[win]) begin mct = mt[win]; mcd = md[win]; end
                else begin mct = pt[win]; mcd = pd[win]; end
                mg = '0; mg[win] = 1'b1;
                mrr = (win + 1) % N;
            end else begin
                mct = '0; mcd = '0; mg = '0;
            end
            for (int i = 0; i < N; i++) begin
                if (pv[i] && rdy[i] && pt[i] != '0 && !byp[i]) begin
                    mf[i] = 1; mt[i] = pt[i]; md[i] = pd[i];
                end else if (win == i) begin
                    mf[i] = 0;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (pv[i] && rdy[i]) pv[i] = 0;
            if (!pv[i] && auto_mask[i] && int'($urandom_range(99)) < prob) begin
                pv[i] = 1; pt[i] = TW'($urandom_range(15)); pd[i] = $urandom;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic async_reset();
        pflush = 0;
        flush  = 0;
        #2 RST = 1'b1;
        #1;
        check("rst_cdb", 64'(cdb_out), 64'h0);
        check("rst_grant", 64'(cdb_grant), 64'h0);
        check("rst_ready", 64'(fu_ready), 64'hF);
        model_reset();
        @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1; flush = 0; fu_valid = '0; fu_tag = '0; fu_data = '0;
        for (int i = 0; i < N; i++) begin auto_mask[i] = 0; pt[i] = '0; pd[i] = '0; end
        model_reset();
        @(posedge CLK);
        #1;
        check("init_cdb", 64'(cdb_out), 64'h0);
        check("init_grant", 64'(cdb_grant), 64'h0);
        check("init_ready", 64'(fu_ready), 64'hF);
        RST = 1'b0;

        // Contention: all FUs at once, rr_ptr=0 -> data 1..4 in order.
        for (int i = 0; i < N; i++) begin pv[i] = 1; pt[i] = TW'(i + 1); pd[i] = 32'(i + 1); end
        repeat (LAT) step();
        for (int k = 0; k < N; k++) begin
            check("cont_data", 64'(cdb_out[31:0]), 64'(k + 1));
            check("cont_grant", 64'(cdb_grant), 64'(1 << k));
            step();
        end

        // Single result on FU2.
        pv[2] = 1; pt[2] = 4'd3; pd[2] = 32'hDEAD_BEEF;
        repeat (LAT) step();
        check("single_cdb", 64'(cdb_out), 64'({4'd3, 32'hDEAD_BEEF}));
        check("single_grant", 64'(cdb_grant), 64'b0100);
        repeat (2) step();

        // Flush with FU0/FU1 results in flight.
        pv[0] = 1; pt[0] = 4'd5; pd[0] = 32'hAAAA_0000;
        pv[1] = 1; pt[1] = 4'd6; pd[1] = 32'hBBBB_0000;
        step();
        pflush = 1;
        step();
        pflush = 0;
        check("flush_tag", 64'(cdb_out[TW+31:32]), 64'h0);
        check("flush_grant", 64'(cdb_grant), 64'h0);
        repeat (4) step();

        // Move rr_ptr to 1 via a lone FU0 result, then stream FU0 and FU3.
        pv[0] = 1; pt[0] = 4'd7; pd[0] = 32'h1234_5678;
        repeat (LAT + 1) step();
        auto_mask[0] = 1; auto_mask[3] = 1; prob = 100;
        for (int i = 0; i < N; i++) if (auto_mask[i]) begin pv[i] = 1; pt[i] = 4'd9; pd[i] = 32'(i); end
        repeat (LAT) step();
        for (int j = 0; j < 8; j++) begin
            check("rr_alt", 64'(cdb_grant), (j % 2 == 0) ? 64'b1000 : 64'b0001);
            step();
        end
        auto_mask[0] = 0; auto_mask[3] = 0;
        repeat (6) step();

        // Random traffic with occasional flush and one mid-cycle reset.
        for (int i = 0; i < N; i++) auto_mask[i] = 1;
        for (int ph = 0; ph < 6; ph++) begin
            prob = 20 + ph * 16;
            for (int c = 0; c < 400; c++) begin
                pflush = ($urandom_range(99) < 2);
                step();
            end
            if (ph == 3) async_reset();
        end
        pflush = 0;
        for (int i = 0; i < N; i++) auto_mask[i] = 0;
        repeat (20) step();
        for (int i = 0; i < N; i++) check("sb_drained", 64'(sb[i].size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
